// File: rtl/ft245_reg_sequencer_if.sv
// Bus bundle between the host command sequencer and its two neighbours:
// the FT245 sync-FIFO wrapper (request/handshake/data lines) and the
// simple internal register bus.
interface ft245_reg_sequencer_if;
  // FT245 wrapper side
  logic       _read_data;
  logic       _write_data;
  logic [7:0] data_to_fpga;
  logic       ft_rd_n;
  logic [7:0] data_to_pc;
  logic       ft_wr_n;
  // Register bus side
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;

  // The sequencer drives requests, reply data and the register bus.
  modport master (
    output _read_data, _write_data, data_to_pc,
    output reg_addr, reg_wdata, reg_we, reg_re,
    input  data_to_fpga, ft_rd_n, ft_wr_n, reg_rdata
  );

  // The wrapper and register file see the mirror image.
  modport slave (
    input  _read_data, _write_data, data_to_pc,
    input  reg_addr, reg_wdata, reg_we, reg_re,
    output data_to_fpga, ft_rd_n, ft_wr_n, reg_rdata
  );
endinterface

// File: rtl/ft245_reg_sequencer.sv
// Host command sequencer sitting on the FT245 sync-FIFO wrapper.
// Takes {rw, addr[6:0]} header bytes from the PC; rw=1 is followed by one
// data byte and produces a register write, rw=0 produces a register read
// whose result is sent back as a single reply byte. Request lines to the
// wrapper are combinational so a byte is never requested twice.
module ft245_reg_sequencer #(
  parameter int TIMEOUT = 65535,
  parameter int CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  ft245_reg_sequencer_if.master        bus,
  output logic                         busy,
  output logic [7:0]                   err_cnt
);

  typedef enum logic [2:0] {
    RX_HDR,
    RX_DATA,
    REG_WR,
    REG_RD,
    RD_WAIT,
    TX
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TMO_MAX  = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] tmo_inc;
  logic [6:0]       reg_addr_q, reg_addr_d;
  logic [7:0]       reg_wdata_q, reg_wdata_d;
  logic [7:0]       data_to_pc_q, data_to_pc_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [7:0]       err_inc;
  logic             reg_we_q, reg_we_d;
  logic             reg_re_q, reg_re_d;

  // Saturating helpers shared by the two waiting states.
  always_comb begin
    tmo_inc = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + CNT_W'(1);
    err_inc = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
  end

  // Packet sequencing: next state, latched fields and abort accounting.
  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;
    data_to_pc_d = data_to_pc_q;
    err_cnt_d    = err_cnt_q;

    case (state_q)
      RX_HDR: begin
        if (!bus.ft_rd_n) begin
          reg_addr_d = bus.data_to_fpga[6:0];
          tmo_d      = '0;
          state_d    = bus.data_to_fpga[7] ? RX_DATA : REG_RD;
        end
      end
      RX_DATA: begin
        if (!bus.ft_rd_n) begin
          reg_wdata_d = bus.data_to_fpga;
          state_d     = REG_WR;
        end else if (tmo_q == TMO_LAST) begin
          err_cnt_d = err_inc;
          state_d   = RX_HDR;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      REG_WR: begin
        state_d = RX_HDR;
      end
      REG_RD: begin
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        data_to_pc_d = bus.reg_rdata;
        tmo_d        = '0;
        state_d      = TX;
      end
      TX: begin
        if (!bus.ft_wr_n) begin
          state_d = RX_HDR;
        end else if (tmo_q == TMO_LAST) begin
          err_cnt_d = err_inc;
          state_d   = RX_HDR;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      default: begin
        state_d = RX_HDR;
      end
    endcase
  end

  // Strobes are registered from the next state so they are high for
  // exactly the cycle spent in REG_WR / REG_RD and glitch-free.
  always_comb begin
    reg_we_d = (state_d == REG_WR);
    reg_re_d = (state_d == REG_RD);
  end

  // State and datapath registers; reset drops any partial packet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RX_HDR;
      tmo_q        <= '0;
      reg_addr_q   <= '0;
      reg_wdata_q  <= '0;
      data_to_pc_q <= '0;
      err_cnt_q    <= '0;
      reg_we_q     <= 1'b0;
      reg_re_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
      data_to_pc_q <= data_to_pc_d;
      err_cnt_q    <= err_cnt_d;
      reg_we_q     <= reg_we_d;
      reg_re_q     <= reg_re_d;
    end
  end

  // Requests drop as soon as the wrapper strobes a byte, and are forced
  // inactive while reset is held, so exactly one byte moves per request.
  assign bus._read_data  = ~(~reset & bus.ft_rd_n &
                             (((state_q == RX_HDR) & en) | (state_q == RX_DATA)));
  assign bus._write_data = ~(~reset & bus.ft_wr_n & (state_q == TX));

  assign bus.reg_addr   = reg_addr_q;
  assign bus.reg_wdata  = reg_wdata_q;
  assign bus.reg_we     = reg_we_q;
  assign bus.reg_re     = reg_re_q;
  assign bus.data_to_pc = data_to_pc_q;
  assign busy           = (state_q != RX_HDR);
  assign err_cnt        = err_cnt_q;

endmodule

// File: tb/tb_ft245_reg_sequencer.sv
// Self-checking bench for ft245_reg_sequencer: plays the FT245 wrapper and a
// register file, and compares against a register-map / error-count model.
module tb_ft245_reg_sequencer;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       busy;
  logic [7:0] err_cnt;

  int total = 0;
  int bad   = 0;

  int we_cnt    = 0;
  int re_cnt    = 0;
  int txreq_cnt = 0;

  bit [7:0]   mem     [128];
  bit         written [128];
  logic [7:0] model_mem [128];

  ft245_reg_sequencer_if bus();

  ft245_reg_sequencer #(.TIMEOUT(TMO), .CNT_W(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .bus     (bus),
    .busy    (busy),
    .err_cnt (err_cnt)
  );

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  // Power-on content of the register file for never-written addresses.
  function automatic logic [7:0] dflt(input logic [6:0] a);
    return {a[3:0], a[6:3]} ^ 8'hA5;
  endfunction

  // Register file: writes land on the strobe, read data appears exactly one
  // cycle after reg_re and is garbage otherwise.
  always @(posedge clk) begin
    if (bus.reg_we === 1'b1) begin
      mem[bus.reg_addr]     <= bus.reg_wdata;
      written[bus.reg_addr] <= 1'b1;
      we_cnt                <= we_cnt + 1;
    end
    if (bus.reg_re === 1'b1) begin
      bus.reg_rdata <= written[bus.reg_addr] ? mem[bus.reg_addr] : dflt(bus.reg_addr);
      re_cnt        <= re_cnt + 1;
    end else begin
      bus.reg_rdata <= 8'($urandom);
    end
  end

  // Count cycles where a TX byte is being requested.
  always @(negedge clk) begin
    if (bus._write_data === 1'b0) txreq_cnt <= txreq_cnt + 1;
  end

  // Global safety net against a hung run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wrapper model: wait for a read request, hand over one byte for one cycle.
  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    ok = 1'b0;
    repeat (gap) step();
    for (int n = 0; n < 64 && !ok; n++) begin
      step();
      if (bus._read_data === 1'b0) begin
        bus.ft_rd_n      = 1'b0;
        bus.data_to_fpga = b;
        step();
        bus.ft_rd_n      = 1'b1;
        bus.data_to_fpga = 8'($urandom);
        ok = 1'b1;
      end
    end
  endtask

  // Wrapper model: wait for a write request, accept one byte for one cycle.
  task automatic take_reply(input int gap, output logic [7:0] b, output bit ok);
    ok = 1'b0;
    b  = 8'h00;
    repeat (gap) step();
    for (int n = 0; n < 64 && !ok; n++) begin
      step();
      if (bus._write_data === 1'b0) begin
        bus.ft_wr_n = 1'b0;
        b = bus.data_to_pc;
        step();
        bus.ft_wr_n = 1'b1;
        ok = 1'b1;
      end
    end
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      step();
    end
  endtask

  // Full write packet; the model learns the new register value.
  task automatic apply_stimulus_write(input logic [6:0] a, input logic [7:0] d, input int g1, input int g2);
    bit ok;
    send_byte({1'b1, a}, g1, ok);
    check_output("wr_hdr_sent", 32'(ok), 1);
    send_byte(d, g2, ok);
    check_output("wr_data_sent", 32'(ok), 1);
    model_mem[a] = d;
  endtask

  initial begin
    bit         ok;
    logic [7:0] rb;
    logic [6:0] a;
    logic [7:0] d;
    int         we0, re0, tq0, n, g1, g2, exp_err;

    exp_err = 0;
    for (int i = 0; i < 128; i++) model_mem[i] = dflt(7'(i));

    reset = 1'b1;
    en = 1'b1;
    bus.ft_rd_n = 1'b1;
    bus.ft_wr_n = 1'b1;
    bus.data_to_fpga = 8'h00;
    repeat (3) step();

    $display("[TB] reset state");
    check_output("rst_read_data", 32'(bus._read_data), 1);
    check_output("rst_write_data", 32'(bus._write_data), 1);
    check_output("rst_busy", 32'(busy), 0);
    check_output("rst_err_cnt", 32'(err_cnt), 0);
    check_output("rst_reg_addr", 32'(bus.reg_addr), 0);
    check_output("rst_data_to_pc", 32'(bus.data_to_pc), 0);
    check_output("rst_reg_we", 32'(bus.reg_we), 0);
    check_output("rst_reg_re", 32'(bus.reg_re), 0);
    reset = 1'b0;
    step();
    check_output("idle_read_req", 32'(bus._read_data), 0);

    $display("[TB] directed write 85/3C");
    we0 = we_cnt; re0 = re_cnt; tq0 = txreq_cnt;
    send_byte(8'h85, 0, ok);
    check_output("w1_hdr_sent", 32'(ok), 1);
    send_byte(8'h3C, 0, ok);
    check_output("w1_data_sent", 32'(ok), 1);
    model_mem[5] = 8'h3C;
    check_output("w1_reg_we", 32'(bus.reg_we), 1);
    check_output("w1_reg_addr", 32'(bus.reg_addr), 32'h05);
    check_output("w1_reg_wdata", 32'(bus.reg_wdata), 32'h3C);
    step();
    check_output("w1_we_drop", 32'(bus.reg_we), 0);
    step();
    check_output("w1_we_count", we_cnt - we0, 1);
    check_output("w1_re_count", re_cnt - re0, 0);
    check_output("w1_no_tx_req", txreq_cnt - tq0, 0);

    $display("[TB] directed read 12 -> A7");
    apply_stimulus_write(7'h12, 8'hA7, 0, 0);
    re0 = re_cnt;
    send_byte(8'h12, 0, ok);
    check_output("r1_hdr_sent", 32'(ok), 1);
    take_reply(0, rb, ok);
    check_output("r1_reply_ok", 32'(ok), 1);
    check_output("r1_reply", 32'(rb), 32'(model_mem[7'h12]));
    check_output("r1_busy_after", 32'(busy), 0);
    step();
    check_output("r1_no_second_req", 32'(bus._write_data), 1);
    check_output("r1_re_count", re_cnt - re0, 1);

    $display("[TB] RX_DATA timeout");
    we0 = we_cnt;
    send_byte(8'h80, 0, ok);
    check_output("t1_hdr_sent", 32'(ok), 1);
    count_busy(n);
    exp_err = exp_err + 1;
    check_output("t1_busy_cycles", n, TMO);
    check_output("t1_err_cnt", 32'(err_cnt), 32'(exp_err));
    check_output("t1_no_we", we_cnt - we0, 0);

    $display("[TB] data byte on the timeout cycle");
    we0 = we_cnt;
    send_byte(8'hC4, 0, ok);
    check_output("t2_hdr_sent", 32'(ok), 1);
    send_byte(8'h6E, TMO - 2, ok);
    check_output("t2_data_sent", 32'(ok), 1);
    model_mem[7'h44] = 8'h6E;
    check_output("t2_reg_wdata", 32'(bus.reg_wdata), 32'h6E);
    step(); step();
    check_output("t2_we_count", we_cnt - we0, 1);
    check_output("t2_err_cnt", 32'(err_cnt), 32'(exp_err));

    $display("[TB] TX timeout");
    send_byte(8'h44, 0, ok);
    check_output("t3_hdr_sent", 32'(ok), 1);
    count_busy(n);
    exp_err = exp_err + 1;
    check_output("t3_busy_cycles", n, TMO + 2);
    check_output("t3_err_cnt", 32'(err_cnt), 32'(exp_err));

    $display("[TB] reply byte on the TX timeout cycle");
    send_byte(8'h44, 0, ok);
    check_output("t4_hdr_sent", 32'(ok), 1);
    take_reply(TMO, rb, ok);
    check_output("t4_reply_ok", 32'(ok), 1);
    check_output("t4_reply", 32'(rb), 32'(model_mem[7'h44]));
    check_output("t4_err_cnt", 32'(err_cnt), 32'(exp_err));

    $display("[TB] back-to-back write/read/write, ft_wr_n held low");
    we0 = we_cnt; re0 = re_cnt;
    apply_stimulus_write(7'h21, 8'h5A, 0, 0);
    send_byte(8'h21, 0, ok);
    check_output("b_hdr_sent", 32'(ok), 1);
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      step();
      if (bus._write_data === 1'b0) ok = 1'b1;
    end
    check_output("b_tx_req_seen", 32'(ok), 1);
    bus.ft_wr_n = 1'b0;
    #1;
    check_output("b_req_gated", 32'(bus._write_data), 1);
    rb = bus.data_to_pc;
    step(); step(); step();
    bus.ft_wr_n = 1'b1;
    check_output("b_reply", 32'(rb), 32'(model_mem[7'h21]));
    check_output("b_left_tx", 32'(busy), 0);
    apply_stimulus_write(7'h22, 8'hC6, 0, 0);
    step(); step();
    check_output("b_we_count", we_cnt - we0, 2);
    check_output("b_re_count", re_cnt - re0, 1);
    check_output("b_err_cnt", 32'(err_cnt), 32'(exp_err));
    check_output("b_write_req_idle", 32'(bus._write_data), 1);

    $display("[TB] en gating");
    en = 1'b0;
    n = 0;
    repeat (5) begin
      step();
      if (bus._read_data !== 1'b1) n++;
    end
    check_output("e_no_hdr_req", n, 0);
    en = 1'b1;
    we0 = we_cnt;
    send_byte(8'hB3, 0, ok);
    check_output("e_hdr_sent", 32'(ok), 1);
    en = 1'b0;
    send_byte(8'h99, 2, ok);
    check_output("e_data_sent", 32'(ok), 1);
    model_mem[7'h33] = 8'h99;
    step(); step();
    check_output("e_we_count", we_cnt - we0, 1);
    check_output("e_idle_no_req", 32'(bus._read_data), 1);
    en = 1'b1;
    send_byte(8'h33, 0, ok);
    take_reply(1, rb, ok);
    check_output("e_readback", 32'(rb), 32'(model_mem[7'h33]));

    $display("[TB] random packets");
    for (int i = 0; i < 40; i++) begin
      a  = 7'($urandom);
      d  = 8'($urandom);
      g1 = int'($urandom_range(0, 6));
      g2 = int'($urandom_range(0, 10));
      we0 = we_cnt; re0 = re_cnt; tq0 = txreq_cnt;
      if ($urandom_range(0, 1) == 1) begin
        apply_stimulus_write(a, d, g1, g2);
        step(); step();
        check_output("rnd_we_count", we_cnt - we0, 1);
        check_output("rnd_we_no_tx", txreq_cnt - tq0, 0);
      end else begin
        send_byte({1'b0, a}, g1, ok);
        check_output("rnd_rd_hdr_sent", 32'(ok), 1);
        take_reply(g2, rb, ok);
        check_output("rnd_rd_reply_ok", 32'(ok), 1);
        check_output("rnd_rd_data", 32'(rb), 32'(model_mem[a]));
        step();
        check_output("rnd_re_count", re_cnt - re0, 1);
      end
    end
    check_output("rnd_err_cnt", 32'(err_cnt), 32'(exp_err));

    $display("[TB] reset in TX");
    send_byte(8'h05, 0, ok);
    check_output("x_hdr_sent", 32'(ok), 1);
    ok = 1'b0;
    for (int i = 0; i < 16 && !ok; i++) begin
      step();
      if (bus._write_data === 1'b0) ok = 1'b1;
    end
    check_output("x_in_tx", 32'(ok), 1);
    reset = 1'b1;
    #1;
    exp_err = 0;
    check_output("x_write_req_off", 32'(bus._write_data), 1);
    check_output("x_err_cleared", 32'(err_cnt), 32'(exp_err));
    check_output("x_busy", 32'(busy), 0);
    step();
    reset = 1'b0;

    $display("[TB] reset mid write packet");
    we0 = we_cnt;
    send_byte(8'h8A, 0, ok);
    check_output("y_hdr_sent", 32'(ok), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (3) step();
    check_output("y_no_we", we_cnt - we0, 0);

    $display("[TB] error counter saturation");
    for (int i = 0; i < 300; i++) begin
      send_byte({1'b1, 7'($urandom)}, 0, ok);
      count_busy(n);
      exp_err = (exp_err >= 255) ? 255 : exp_err + 1;
      if (i == 0 || exp_err >= 253 || !ok) begin
        check_output("s_hdr_sent", 32'(ok), 1);
        check_output("s_err_cnt", 32'(err_cnt), 32'(exp_err));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
